// File: rtl/vga_sprite_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_sprite_pkg - shared widths, fetch state encoding, scaled box test. Rev 1.0
//------------------------------------------------------------------------------
package vga_sprite_pkg;

  localparam int H_W     = 12;
  localparam int V_W     = 11;
  localparam int MADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // rel is a two's complement offset; neg carries its sign bit.
  function automatic logic in_scaled(input logic [H_W-1:0] rel,
                                     input logic           neg,
                                     input logic [H_W-1:0] size,
                                     input logic [1:0]     scale_log2);
    logic [H_W-1:0] lim;
    lim = size << scale_log2;
    return !neg && (rel < lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_line_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// sprite_line_fetch - per-line row prefetch over req/ack into a double line buffer. Rev 1.0
//------------------------------------------------------------------------------
module sprite_line_fetch
  import vga_sprite_pkg::*;
#(
  parameter int XSIZE = 16,
  parameter int YSIZE = 16,
  parameter int BPP   = 1
) (
  input  logic                     px_clk,
  input  logic                     rst,
  input  logic                     line_begin,
  input  logic [V_W-1:0]           v_addr,
  input  logic [V_W-1:0]           y_loc,
  input  logic [MADDR_W-1:0]       base,
  input  logic [1:0]               scale_log2,
  input  logic                     vflip,
  output logic                     mem_req,
  output logic [MADDR_W-1:0]       mem_addr,
  input  logic                     mem_ack,
  input  logic [XSIZE*BPP-1:0]     mem_rdata,
  output logic [XSIZE*BPP-1:0]     disp_buf,
  output logic                     fetch_miss
);

  localparam int DW = XSIZE * BPP;

  fetch_state_t        r_state;
  fetch_state_t        w_next;
  logic [MADDR_W-1:0]  r_addr;
  logic [DW-1:0]       r_fetch;
  logic [DW-1:0]       r_disp;
  logic                r_miss;

  logic [V_W-1:0]      w_nrel;
  logic                w_nrel_ok;
  logic [V_W-1:0]      w_row_full;
  logic [MADDR_W-1:0]  w_row;
  logic                unused_row;

  // Row needed by the line after the current one.
  assign w_nrel     = v_addr + V_W'(1) - y_loc;
  assign w_nrel_ok  = in_scaled({1'b0, w_nrel}, w_nrel[V_W-1], H_W'(YSIZE), scale_log2);
  assign w_row_full = w_nrel >> scale_log2;
  assign w_row      = vflip ? MADDR_W'(YSIZE - 1) - w_row_full[MADDR_W-1:0]
                            : w_row_full[MADDR_W-1:0];
  assign unused_row = &{1'b0, w_row_full[V_W-1:MADDR_W]};

  always_ff @(posedge px_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (line_begin)
      w_next = w_nrel_ok ? REQ : IDLE;
    else if (r_state == REQ && mem_ack)
      w_next = DONE;
  end

  always_comb begin
    mem_req  = (r_state == REQ);
    mem_addr = r_addr;
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_fetch <= '0;
      r_disp  <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_miss <= line_begin && (r_state == REQ);
      if (line_begin) begin
        // An unfinished fetch leaves the new line blank.
        r_disp <= (r_state == DONE) ? r_fetch : '0;
        if (w_nrel_ok) r_addr <= base + w_row;
      end
      if (r_state == REQ && mem_ack && !line_begin) r_fetch <= mem_rdata;
    end
  end

  assign disp_buf   = r_disp;
  assign fetch_miss = r_miss;

endmodule
`default_nettype wire

// File: rtl/vga_sprite_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_sprite_engine - scaled multi-bpp sprite renderer; SPRITE_MIRROR_EN adds h/v flip. Rev 1.0
//------------------------------------------------------------------------------
module vga_sprite_engine
  import vga_sprite_pkg::*;
#(
  parameter int                 XSIZE        = 16,
  parameter int                 YSIZE        = 16,
  parameter int                 BPP          = 1,
  parameter int                 XLOC_INITIAL = 0,
  parameter int                 YLOC_INITIAL = 0,
  parameter logic [MADDR_W-1:0] BASE_INITIAL = 9'h0a0
) (
  input  logic                 px_clk,
  input  logic                 rst,
  input  logic [15:0]          data_in,
  input  logic                 x_loc_en,
  input  logic                 y_loc_en,
  input  logic                 base_wren,
  input  logic                 scale_wren,
  input  logic                 frame_begin,
  input  logic                 line_begin,
  input  logic [H_W-1:0]       h_addr,
  input  logic [V_W-1:0]       v_addr,
  output logic                 mem_req,
  output logic [MADDR_W-1:0]   mem_addr,
  input  logic                 mem_ack,
  input  logic [XSIZE*BPP-1:0] mem_rdata,
  output logic                 sprite_on,
  output logic [BPP-1:0]       pixel_val,
  output logic                 fetch_miss
);

  localparam int CW = $clog2(XSIZE);
  localparam int DW = XSIZE * BPP;

  logic [H_W-1:0]     r_x_pend, r_x_act;
  logic [V_W-1:0]     r_y_pend, r_y_act;
  logic [MADDR_W-1:0] r_base_pend, r_base_act;
  logic [1:0]         r_scale;
  logic               r_on;
  logic [BPP-1:0]     r_val;
  logic               w_hflip, w_vflip;

  // Writes coinciding with frame_begin bypass the pending stage.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_x_pend    <= H_W'(XLOC_INITIAL);
      r_x_act     <= H_W'(XLOC_INITIAL);
      r_y_pend    <= V_W'(YLOC_INITIAL);
      r_y_act     <= V_W'(YLOC_INITIAL);
      r_base_pend <= BASE_INITIAL;
      r_base_act  <= BASE_INITIAL;
      r_scale     <= 2'd0;
    end else begin
      if (x_loc_en)   r_x_pend    <= data_in[H_W-1:0];
      if (y_loc_en)   r_y_pend    <= data_in[V_W-1:0];
      if (base_wren)  r_base_pend <= data_in[MADDR_W-1:0];
      if (scale_wren) r_scale     <= data_in[1:0];
      if (frame_begin) begin
        r_x_act    <= x_loc_en  ? data_in[H_W-1:0]     : r_x_pend;
        r_y_act    <= y_loc_en  ? data_in[V_W-1:0]     : r_y_pend;
        r_base_act <= base_wren ? data_in[MADDR_W-1:0] : r_base_pend;
      end
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic r_hflip_pend, r_hflip_act, r_vflip_pend, r_vflip_act;

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_hflip_pend <= 1'b0;
      r_hflip_act  <= 1'b0;
      r_vflip_pend <= 1'b0;
      r_vflip_act  <= 1'b0;
    end else begin
      if (x_loc_en) r_hflip_pend <= data_in[15];
      if (y_loc_en) r_vflip_pend <= data_in[14];
      if (frame_begin) begin
        r_hflip_act <= x_loc_en ? data_in[15] : r_hflip_pend;
        r_vflip_act <= y_loc_en ? data_in[14] : r_vflip_pend;
      end
    end
  end

  assign w_hflip = r_hflip_act;
  assign w_vflip = r_vflip_act;
`else
  assign w_hflip = 1'b0;
  assign w_vflip = 1'b0;
`endif

  logic [H_W-1:0] w_rel_x;
  logic [V_W-1:0] w_rel_y;
  logic           w_in_x, w_in_y;
  logic [H_W-1:0] w_col_full;
  logic [CW-1:0]  w_col;
  logic [DW-1:0]  w_disp_buf;
  logic [BPP-1:0] w_pix_arr [XSIZE];
  logic [BPP-1:0] w_pix;
  logic           unused_bits;

  assign w_rel_x    = h_addr - r_x_act;
  assign w_rel_y    = v_addr - r_y_act;
  assign w_in_x     = in_scaled(w_rel_x, w_rel_x[H_W-1], H_W'(XSIZE), r_scale);
  assign w_in_y     = in_scaled({1'b0, w_rel_y}, w_rel_y[V_W-1], H_W'(YSIZE), r_scale);
  assign w_col_full = w_rel_x >> r_scale;
  assign w_col      = w_hflip ? ~w_col_full[CW-1:0] : w_col_full[CW-1:0];
  assign unused_bits = &{1'b0, data_in[15:12], w_col_full[H_W-1:CW]};

  // Pixel 0 lives in the most significant bits of the row word.
  for (genvar gi = 0; gi < XSIZE; gi++) begin : g_unpack
    assign w_pix_arr[gi] = w_disp_buf[(XSIZE-1-gi)*BPP +: BPP];
  end

  assign w_pix = w_pix_arr[w_col];

  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_on  <= 1'b0;
      r_val <= '0;
    end else begin
      r_on  <= w_in_x && w_in_y && (w_pix != '0);
      r_val <= (w_in_x && w_in_y) ? w_pix : '0;
    end
  end

  assign sprite_on = r_on;
  assign pixel_val = r_val;

  sprite_line_fetch #(
    .XSIZE (XSIZE),
    .YSIZE (YSIZE),
    .BPP   (BPP)
  ) u_fetch (
    .px_clk     (px_clk),
    .rst        (rst),
    .line_begin (line_begin),
    .v_addr     (v_addr),
    .y_loc      (r_y_act),
    .base       (r_base_act),
    .scale_log2 (r_scale),
    .vflip      (w_vflip),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .disp_buf   (w_disp_buf),
    .fetch_miss (fetch_miss)
  );

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_vga_sprite_engine - directed frames against a 1bpp and a 2bpp instance. Rev 1.0
//------------------------------------------------------------------------------
module tb_vga_sprite_engine;

  localparam int HT = 232;

  logic        px_clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        x_loc_en, y_loc_en, base_wren, scale_wren;
  logic        frame_begin, line_begin;
  logic [11:0] h_addr;
  logic [10:0] v_addr;
  logic        mem_req, mem_ack, sprite_on, fetch_miss;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [0:0]  pixel_val;

  logic        mem_req2, mem_ack2, sprite_on2, fetch_miss2;
  logic [8:0]  mem_addr2;
  logic [31:0] mem_rdata2;
  logic [1:0]  pixel_val2;

  int n_vec = 0;
  int n_bad = 0;

  int         pat, miss_v, ex_x, pend_x, ex_scale;
  logic       ex_hf, pend_hf;
  logic [8:0] hold_addr;

  always #5 px_clk = ~px_clk;

  vga_sprite_engine u_dut (
    .px_clk(px_clk), .rst(rst), .data_in(data_in),
    .x_loc_en(x_loc_en), .y_loc_en(y_loc_en), .base_wren(base_wren), .scale_wren(scale_wren),
    .frame_begin(frame_begin), .line_begin(line_begin), .h_addr(h_addr), .v_addr(v_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sprite_on(sprite_on), .pixel_val(pixel_val), .fetch_miss(fetch_miss)
  );

  vga_sprite_engine #(.BPP(2), .XLOC_INITIAL(100), .YLOC_INITIAL(50)) u_dut2 (
    .px_clk(px_clk), .rst(rst), .data_in(16'h0000),
    .x_loc_en(1'b0), .y_loc_en(1'b0), .base_wren(1'b0), .scale_wren(1'b0),
    .frame_begin(frame_begin), .line_begin(line_begin), .h_addr(h_addr), .v_addr(v_addr),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
    .sprite_on(sprite_on2), .pixel_val(pixel_val2), .fetch_miss(fetch_miss2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (v=%0d h=%0d)", tag, got, exp, v_addr, h_addr);
    end
  endtask

  function automatic logic [15:0] row_word(input int p, input logic [8:0] a);
    logic [15:0] w;
    if (p == 0)      w = 16'h8001;
    else if (p == 1) w = a[0] ? 16'h0001 : 16'h8000;
    else             w = 16'h8000;
    return w;
  endfunction

  // Sprite geometry: y fixed at 50, base 0x0a0, 16x16 scaled by 2**ex_scale.
  function automatic logic exp_on(input int h, input int v);
    int rx, ry, sz, col, row;
    logic [15:0] w;
    rx = h - ex_x;
    ry = v - 50;
    sz = 16 << ex_scale;
    if (rx < 0 || rx >= sz || ry < 0 || ry >= sz || v == miss_v) return 1'b0;
    col = rx >> ex_scale;
    if (ex_hf) col = 15 - col;
    row = ry >> ex_scale;
    w = row_word(pat, 9'(160 + row));
    return w[15 - col];
  endfunction

  // Memory for u_dut: acks two cycles into a request unless the address is held off.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge px_clk); #1;
      mem_ack = 1'b0;
      if (mem_req && mem_addr != hold_addr) begin
        if (cnt == 2) begin
          mem_ack = 1'b1;
          mem_rdata = row_word(pat, mem_addr);
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    mem_ack2 = 1'b0;
    mem_rdata2 = 32'h8000_0001;
    forever begin
      @(posedge px_clk); #1;
      mem_ack2 = mem_req2;
    end
  end

  task automatic cpu(input int sel, input logic [15:0] d);
    data_in = d;
    x_loc_en = (sel == 0);
    y_loc_en = (sel == 1);
    scale_wren = (sel == 2);
    line_begin = 1'b0;
    frame_begin = 1'b0;
    @(posedge px_clk); #1;
    x_loc_en = 1'b0; y_loc_en = 1'b0; scale_wren = 1'b0;
    if (sel == 0) begin
      pend_x = int'(d[11:0]);
`ifdef SPRITE_MIRROR_EN
      pend_hf = d[15];
`endif
    end
    if (sel == 2) ex_scale = int'(d[1:0]);
  endtask

  task automatic run_frame(input int v0, input int v1, input int wr_v, input int wr_h,
                           input logic [15:0] wr_d);
    for (int v = v0; v <= v1; v++) begin
      for (int h = 0; h < HT; h++) begin
        logic e_on;
        int   e2;
        frame_begin = (v == v0 && h == 0);
        line_begin  = (h == 0);
        h_addr = 12'(h);
        v_addr = 11'(v);
        x_loc_en = (v == wr_v && h == wr_h);
        data_in = wr_d;
        e_on = exp_on(h, v);
        e2 = (v >= 50 && v <= 65) ? ((h == 100) ? 2 : (h == 115) ? 1 : 0) : 0;
        @(posedge px_clk); #1;
        if (frame_begin) begin
          ex_x  = x_loc_en ? int'(wr_d[11:0]) : pend_x;
          ex_hf = pend_hf;
        end
        if (x_loc_en) pend_x = int'(wr_d[11:0]);
        check_val("on", 32'(sprite_on), 32'(e_on));
        check_val("val", 32'(pixel_val), 32'(e_on));
        check_val("miss", 32'(fetch_miss), 32'(v == miss_v && h == 0));
        check_val("on2", 32'(sprite_on2), 32'(e2 != 0));
        check_val("val2", 32'(pixel_val2), 32'(e2));
        if (v == miss_v && h == 0) begin
          check_val("req_after_miss", 32'(mem_req), 32'd1);
          check_val("addr_after_miss", 32'(mem_addr), 32'h0a4);
        end
        if (h == HT - 1) check_val("req_eol", 32'(mem_req), 32'(v == miss_v - 1));
      end
    end
    x_loc_en = 1'b0;
    line_begin = 1'b0;
    frame_begin = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0;
    x_loc_en = 1'b0; y_loc_en = 1'b0; base_wren = 1'b0; scale_wren = 1'b0;
    frame_begin = 1'b0; line_begin = 1'b0;
    h_addr = '0; v_addr = '0;
    pat = 0; miss_v = -10; hold_addr = 9'h1ff;
    ex_x = 0; pend_x = 0; ex_scale = 0; ex_hf = 1'b0; pend_hf = 1'b0;

    repeat (3) @(posedge px_clk);
    #1;
    check_val("rst_on", 32'(sprite_on), 32'd0);
    check_val("rst_val", 32'(pixel_val), 32'd0);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_miss", 32'(fetch_miss), 32'd0);
    rst = 1'b0;

    cpu(0, 16'd100);
    cpu(1, 16'd50);

    // Row 3 is never acknowledged; x=200 is written mid-frame.
    miss_v = 53; hold_addr = 9'h0a3;
    run_frame(48, 68, 55, 10, 16'd200);
    miss_v = -10; hold_addr = 9'h1ff;

    run_frame(48, 68, -1, 0, 16'd0);

    cpu(2, 16'd2);
    pat = 1;
    run_frame(48, 116, 48, 0, 16'd100);

`ifdef SPRITE_MIRROR_EN
    cpu(2, 16'd0);
    pat = 2;
    cpu(0, 16'h8064);
    run_frame(48, 68, -1, 0, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised successor to the single-colour pong sprite.
- Renders one XSIZE×YSIZE sprite with BPP bits per pixel, a runtime power-of-two scale, and a frame-synchronous position commit.
- Prefetches each sprite row over a req/ack memory handshake during the preceding line into a double line buffer.
- Sits between the VGA timing generator (h_addr/v_addr/line_begin/frame_begin) and the pixel colour mux.

Parameters:
- XSIZE, 16, sprite width in pixels (power of two, 8..32)
- YSIZE, 16, sprite height in rows (2..64)
- BPP, 1, bits per pixel (1 or 2); pixel value 0 = transparent
- XLOC_INITIAL, 0, reset x position
- YLOC_INITIAL, 0, reset y position
- BASE_INITIAL, 9'h0a0, reset sprite memory base address

Ports:
- px_clk  in  1  pixel clock
- rst  in  1  reset
- data_in  in  16  CPU write data
- x_loc_en  in  1  write pending x = data_in[11:0]
- y_loc_en  in  1  write pending y = data_in[10:0]
- base_wren  in  1  write pending base = data_in[8:0]
- scale_wren  in  1  write scale_log2 = data_in[1:0] (applied immediately)
- frame_begin  in  1  one-cycle pulse, first pixel of frame
- line_begin  in  1  one-cycle pulse, first pixel of each line
- h_addr  in  12  current pixel column
- v_addr  in  11  current pixel row
- mem_req  out  1  row fetch request
- mem_addr  out  9  row address = base + row
- mem_ack  in  1  mem_rdata valid this cycle
- mem_rdata  in  XSIZE*BPP  row data, pixel 0 in MSBs
- sprite_on  out  1  registered: pixel non-transparent and inside box
- pixel_val  out  BPP  registered pixel value (0 when sprite_on = 0)
- fetch_miss  out  1  one-cycle pulse: row fetch not completed by line_begin

Behaviour:
- Reset: rst synchronous, active-high; clock px_clk.
- Reset values: x/y/base active and pending = *_INITIAL; scale_log2 = 0; both line buffers 0; FSM IDLE; mem_req, sprite_on, pixel_val, fetch_miss = 0.
- Position commit: x/y/base writes land in pending registers and are copied to active on frame_begin. A write coinciding with frame_begin goes straight to active.
- Box test: rel_x = h_addr - x_loc (12 bit), rel_y = v_addr - y_loc (11 bit).
  - inX = !rel_x[11] && rel_x < XSIZE<<scale_log2.
  - inY is defined likewise on rel_y against YSIZE<<scale_log2.
- Pixel select: col = rel_x >> scale_log2; the pixel is taken from the display buffer, MSB-first.
- Output timing: sprite_on/pixel_val are registered, 1 px_clk latency from h_addr.
- Fetch FSM states:
  - IDLE: on line_begin, compute nrel = v_addr + 1 - y_loc. If nrel is in range, go to REQ; else stay IDLE.
  - REQ: mem_req = 1, mem_addr = base + (nrel >> scale_log2); mem_addr is held stable. On mem_ack, latch mem_rdata into the fetch buffer, drop mem_req, go to DONE.
  - DONE: wait.
- Buffer swap on line_begin (any state): the display buffer takes the fetch buffer if the state is DONE, else 0.
  - If the state was REQ, pulse fetch_miss, drop mem_req, and re-evaluate as from IDLE in the same cycle.
- Last-line wrap: nrel for the last visible row is out of range, so the next frame's row 0 is fetched from the final line of blanking. The timing generator guarantees a line_begin there.
- scale_wren mid-frame takes effect on the next pixel/row computation; no flush.
- Address wrap: base + row wraps modulo 512.
- rst mid-fetch returns to IDLE immediately; no ack is expected afterwards.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- Defined:
  - data_in[15] on x_loc_en sets the pending hflip bit; data_in[14] on y_loc_en sets the pending vflip bit.
  - Both commit with the position on frame_begin.
  - hflip: col = XSIZE-1 - col. vflip: row = YSIZE-1 - row at fetch.
- Undefined: no flip registers; data_in[15:12] on x writes and data_in[15:11] on y writes are ignored.

Decomposition:
- Package vga_sprite_pkg:
  - fetch state enum (IDLE/REQ/DONE)
  - H_W = 12, V_W = 11, MADDR_W = 9
  - function for the scaled-size compare
- Sub-module sprite_line_fetch: FSM, mem handshake, fetch/display buffers, fetch_miss.
- The top level holds the registers, box test and pixel select.

Test Plan:
- Reset, XLOC/YLOC = 100/50, scale 0, row data 16'h8001 → sprite_on at h = 100 and 115 only (1 cycle later), v = 50..65; none elsewhere.
- scale_log2 = 2 → box 64×64. Each memory row is repeated for 4 lines; each bit for 4 pixels.
- x write of 200 mid-frame → position unchanged until next frame_begin; write coinciding with frame_begin → effective that frame.
- Withhold mem_ack past line_begin → fetch_miss pulses once, that line is blank, mem_req drops, next row fetched normally.
- BPP = 2, row word with pixel value 2'b00 in a column → sprite_on = 0 there; value 2'b10 → pixel_val = 2 with sprite_on = 1.
- SPRITE_MIRROR_EN, hflip set, data 16'h8000 at x = 100 → pixel lit at h = 115, not 100.
